// File: rtl/spi_slave_param.sv
// SPI slave front-end for the single-port RAM: cmd+payload frames in on mosi, read data out on miso.
// Define SPI_FRAME_ERR_EN to expose the frame_err pulse (abort, TX timeout, read-sequence error).
module spi_slave_param #(
   parameter int DATA_W     = 8,
   parameter int TX_TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ss_n,
   input  logic              mosi,
   output logic              miso,
   output logic [DATA_W+1:0] rx_data,
   output logic              rx_valid,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid
`ifdef SPI_FRAME_ERR_EN
   ,
   output logic              frame_err
`endif
);

   localparam int FRAME_W = DATA_W + 2;
   localparam int CNT_W   = $clog2(FRAME_W + 1);
   localparam int TMO_W   = (TX_TIMEOUT > 0) ? $clog2(TX_TIMEOUT + 1) : 1;

   localparam logic [CNT_W-1:0] RX_LAST  = CNT_W'(FRAME_W - 1);
   localparam logic [CNT_W-1:0] TX_LAST  = CNT_W'(DATA_W - 1);
   localparam logic [TMO_W-1:0] TMO_LAST = (TX_TIMEOUT > 0) ? TMO_W'(TX_TIMEOUT - 1) : '0;

   typedef enum logic [2:0] {IDLE, CHK_CMD, RX, TX_WAIT, TX_SHIFT, DONE} state_t;

   state_t             state, next_state;
   logic [FRAME_W-2:0] frame_sr;
   logic [FRAME_W-1:0] frame_full;
   logic [CNT_W-1:0]   bit_cnt;
   logic [TMO_W-1:0]   tmo_cnt;
   logic [DATA_W-1:0]  shreg;
   logic               rd_addr_seen;
   logic               active, abort, rx_last, rd_addr_cmd, rd_data_cmd;
   logic               seq_err, rx_done, tx_accept, timeout, tx_last;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // NOTE: every signal gets a default before any branch, so no path can infer a latch.
   always_comb begin
      frame_full  = {frame_sr, mosi};
      rd_addr_cmd = (frame_full[FRAME_W-1 -: 2] == 2'b10);
      rd_data_cmd = (frame_full[FRAME_W-1 -: 2] == 2'b11);
      active      = state inside {CHK_CMD, RX, TX_WAIT, TX_SHIFT};
      abort       = active && ss_n;
      rx_last     = (state == RX) && !ss_n && (bit_cnt == RX_LAST);
      seq_err     = rx_last && rd_data_cmd && !rd_addr_seen;
      rx_done     = rx_last && !seq_err;
      tx_accept   = (state == TX_WAIT) && !ss_n && tx_valid;
      // A tx_valid arriving on the expiry cycle wins over the timeout.
      timeout     = (TX_TIMEOUT > 0) && (state == TX_WAIT) && !ss_n && !tx_valid
                    && (tmo_cnt == TMO_LAST);
      tx_last     = (state == TX_SHIFT) && !ss_n && (bit_cnt == TX_LAST);

      next_state = state;
      if (abort) begin
         next_state = IDLE;
      end else begin
         case (state)
            IDLE:     if (!ss_n) next_state = CHK_CMD;
            CHK_CMD:  next_state = RX;
            RX:       if (rx_last) next_state = (rd_data_cmd && !seq_err) ? TX_WAIT : DONE;
            TX_WAIT:  if (tx_accept) next_state = TX_SHIFT;
                      else if (timeout) next_state = DONE;
            TX_SHIFT: if (tx_last) next_state = DONE;
            DONE:     if (ss_n) next_state = IDLE;
            default:  next_state = IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         miso         <= 1'b0;
         rx_valid     <= 1'b0;
         rx_data      <= '0;
         rd_addr_seen <= 1'b0;
         frame_sr     <= '0;
         bit_cnt      <= '0;
         tmo_cnt      <= '0;
         shreg        <= '0;
      end else begin
         rx_valid <= rx_done;
         if (rx_done) rx_data <= frame_full;

         if (rx_last && rd_addr_cmd)      rd_addr_seen <= 1'b1;
         else if (rx_done && rd_data_cmd) rd_addr_seen <= 1'b0;

         // Exactly FRAME_W-1 bits shift in before completion, so stale bits fall out.
         if ((state == CHK_CMD || state == RX) && !ss_n) frame_sr <= frame_full[FRAME_W-2:0];

         case (state)
            CHK_CMD:      bit_cnt <= CNT_W'(1);
            RX, TX_SHIFT: bit_cnt <= bit_cnt + 1'b1;
            default:      bit_cnt <= '0;
         endcase

         if (state == TX_WAIT) tmo_cnt <= (tmo_cnt == '1) ? tmo_cnt : tmo_cnt + 1'b1;
         else                  tmo_cnt <= '0;

         if (tx_accept)              shreg <= tx_data;
         else if (state == TX_SHIFT) shreg <= shreg << 1;

         miso <= (state == TX_SHIFT && !ss_n) ? shreg[DATA_W-1] : 1'b0;
      end
   end

`ifdef SPI_FRAME_ERR_EN
   always_ff @(posedge clk) begin
      if (rst) frame_err <= 1'b0;
      else     frame_err <= abort || timeout || seq_err;
   end
`endif

endmodule

// File: tb/tb_spi_slave_param.sv
// Directed bench for spi_slave_param: write/read frames, abort, read-sequence error, TX timeout, reset.
// frame_err checks are compiled in only when SPI_FRAME_ERR_EN is defined.
module tb_spi_slave_param;

   localparam int DATA_W     = 8;
   localparam int TX_TIMEOUT = 16;
   localparam int FRAME_W    = DATA_W + 2;

   logic               clk = 1'b0;
   logic               rst, ss_n, mosi, miso, rx_valid, tx_valid;
   logic [FRAME_W-1:0] rx_data;
   logic [DATA_W-1:0]  tx_data;
`ifdef SPI_FRAME_ERR_EN
   logic               frame_err;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   spi_slave_param #(.DATA_W(DATA_W), .TX_TIMEOUT(TX_TIMEOUT)) dut (
      .clk      (clk),
      .rst      (rst),
      .ss_n     (ss_n),
      .mosi     (mosi),
      .miso     (miso),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .tx_data  (tx_data),
      .tx_valid (tx_valid)
`ifdef SPI_FRAME_ERR_EN
      ,
      .frame_err(frame_err)
`endif
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1 ns after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_err(input string tag, input logic exp);
`ifdef SPI_FRAME_ERR_EN
      check(tag, frame_err, exp);
`endif
   endtask

   // Drops ss_n and clocks out one frame MSB first; counts rx_valid seen before the last bit.
   task automatic send_frame(input logic [FRAME_W-1:0] f, output int early);
      early = 0;
      ss_n = 1'b0;
      tick();
      for (int i = FRAME_W - 1; i >= 0; i--) begin
         mosi = f[i];
         tick();
         if (i != 0 && rx_valid) early++;
      end
      mosi = 1'b0;
   endtask

   task automatic shift_out(output logic [DATA_W-1:0] got);
      got = '0;
      for (int k = 0; k < DATA_W; k++) begin
         tick();
         got = {got[DATA_W-2:0], miso};
      end
   endtask

   task automatic release_ss();
      ss_n = 1'b1;
      tick();
   endtask

   initial begin
      int                 early;
      logic               hi;
      logic [DATA_W-1:0]  got;
      logic [DATA_W-1:0]  exp_byte;
      logic [FRAME_W-1:0] f;

      rst = 1'b1; ss_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0; tx_data = '0;
      tick();
      tick();
      check("reset miso", miso, 0);
      check("reset rx_valid", rx_valid, 0);
      check("reset rx_data", rx_data, 0);
      check_err("reset frame_err", 1'b0);
      rst = 1'b0;
      tick();

      // T1: write address frame, then DONE ignores mosi until ss_n rises
      send_frame(10'h0A5, early);
      check("t1 early rx_valid", early, 0);
      check("t1 rx_valid", rx_valid, 1);
      check("t1 rx_data", rx_data, 10'h0A5);
      check("t1 miso", miso, 0);
      hi = 1'b0;
      for (int i = 0; i < 3; i++) begin
         mosi = 1'b1;
         tick();
         hi |= rx_valid | miso;
      end
      check("t1 done quiet", hi, 0);
      mosi = 1'b0;
      release_ss();
      check_err("t1 ss_n in done", 1'b0);

      // T2: read address then read data, C3 shifted out
      send_frame(10'h203, early);
      check("t2 addr rx_valid", rx_valid, 1);
      check("t2 addr rx_data", rx_data, 10'h203);
      release_ss();
      check("t2 rx_valid pulse", rx_valid, 0);
      send_frame(10'h300, early);
      check("t2 data rx_valid", rx_valid, 1);
      check("t2 data rx_data", rx_data, 10'h300);
      tick();
      tick();
      tx_valid = 1'b1; tx_data = 8'hC3;
      tick();
      tx_valid = 1'b0; tx_data = '0;
      check("t2 miso at accept", miso, 0);
      exp_byte = 8'hC3;
      for (int k = 0; k < DATA_W; k++) begin
         tick();
         check("t2 miso bit", miso, exp_byte[DATA_W-1-k]);
      end
      tick();
      check("t2 miso after", miso, 0);
      check_err("t2 no err", 1'b0);
      release_ss();

      // T3: abort after 5 bits, then a clean frame still works
      ss_n = 1'b0;
      tick();
      f = 10'h1F0;
      for (int i = FRAME_W - 1; i >= FRAME_W - 5; i--) begin
         mosi = f[i];
         tick();
      end
      ss_n = 1'b1; mosi = 1'b0;
      tick();
      check("t3 no rx_valid", rx_valid, 0);
      check("t3 rx_data held", rx_data, 10'h300);
      check("t3 miso", miso, 0);
      check_err("t3 abort err", 1'b1);
      tick();
      check_err("t3 err pulse end", 1'b0);
      send_frame(10'h15A, early);
      check("t3 next early", early, 0);
      check("t3 next rx_valid", rx_valid, 1);
      check("t3 next rx_data", rx_data, 10'h15A);
      release_ss();

      // T4: read data without read address after reset
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      send_frame(10'h300, early);
      check("t4 rx_valid suppressed", rx_valid, 0);
      check("t4 rx_data", rx_data, 0);
      check_err("t4 seq err", 1'b1);
      tx_valid = 1'b1; tx_data = 8'hFF;
      hi = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         hi |= miso | rx_valid;
      end
      check("t4 no shift", hi, 0);
      tx_valid = 1'b0;
      release_ss();
      // write frames between read address and read data keep the pairing
      send_frame(10'h2AA, early);
      release_ss();
      send_frame(10'h011, early);
      check("t4 write rx_data", rx_data, 10'h011);
      release_ss();
      send_frame(10'h3FF, early);
      check("t4 rd after wr", rx_valid, 1);
      check("t4 rd rx_data", rx_data, 10'h3FF);
      tx_valid = 1'b1; tx_data = 8'h5A;
      tick();
      tx_valid = 1'b0;
      shift_out(got);
      check("t4 shifted", got, 8'h5A);
      release_ss();

      // T5a: TX timeout after 16 cycles in TX_WAIT
      send_frame(10'h2A1, early);
      release_ss();
      send_frame(10'h300, early);
      check("t5 rx_valid", rx_valid, 1);
      for (int i = 0; i < TX_TIMEOUT - 1; i++) begin
         tick();
         check_err("t5 no early err", 1'b0);
      end
      tick();
      check_err("t5 timeout err", 1'b1);
      tx_valid = 1'b1; tx_data = 8'hFF;
      hi = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         hi |= miso;
      end
      check("t5 no shift after timeout", hi, 0);
      tx_valid = 1'b0;
      release_ss();

      // T5b: tx_valid on the expiry cycle is accepted
      send_frame(10'h2A1, early);
      release_ss();
      send_frame(10'h300, early);
      for (int i = 0; i < TX_TIMEOUT - 1; i++) tick();
      tx_valid = 1'b1; tx_data = 8'hC3;
      tick();
      tx_valid = 1'b0; tx_data = '0;
      check_err("t5b no err", 1'b0);
      shift_out(got);
      check("t5b shifted", got, 8'hC3);
      release_ss();

      // T6: reset during TX_SHIFT clears everything including rd_addr_seen
      send_frame(10'h2A1, early);
      release_ss();
      send_frame(10'h300, early);
      tx_valid = 1'b1; tx_data = 8'hFF;
      tick();
      tx_valid = 1'b0;
      tick();
      tick();
      tick();
      check("t6 shifting", miso, 1);
      rst = 1'b1;
      tick();
      check("t6 reset miso", miso, 0);
      check("t6 reset rx_valid", rx_valid, 0);
      check("t6 reset rx_data", rx_data, 0);
      check_err("t6 reset err", 1'b0);
      rst = 1'b0; ss_n = 1'b1;
      tick();
      send_frame(10'h300, early);
      check("t6 rd flagged", rx_valid, 0);
      check_err("t6 seq err", 1'b1);
      release_ss();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
